cond_code_unit: RTL and testbench
=================================

// Module: cond_code_unit
// PURPOSE
//  Condition-code responder for the fetch/decode/execute control FSM. Watches the FSM
//  state bus, evaluates the fetched instruction's 4-bit condition field against the
//  NZCV flag register, and returns condition_code_check in LOAD_REG_STATE. Updates the
//  flags after ALU_STATE and keeps saturating executed/skipped instruction counters.
// PARAMETERS
//  IDLE_STATE      2'd0  state encoding: idle
//  FETCH_STATE     2'd1  state encoding: instruction fetch
//  LOAD_REG_STATE  2'd2  state encoding: register load / condition check
//  ALU_STATE       2'd3  state encoding: ALU execute
//  CNT_W           16    width of executed/skipped counters
// PORTS
//  clk                   in   1      clock
//  rst_n                 in   1      reset, asynchronous, active-low
//  curr_state            in   2      control FSM current state
//  cond_in               in   4      instruction condition field, valid all of LOAD_REG_STATE
//  set_flags             in   1      instruction S-bit; sampled at the edge ending ALU_STATE
//  alu_nzcv              in   4      ALU result flags {N,Z,C,V}, valid in ALU_STATE
//  flags_wr              in   1      direct flag write request (honoured in IDLE_STATE only)
//  flags_wdata           in   4      direct flag write data {N,Z,C,V}
//  cnt_clr               in   1      synchronous clear of both counters
//  condition_code_check  out  1      1 = execute instruction (to control FSM)
//  flags                 out  4      current {N,Z,C,V}
//  exec_cnt              out  CNT_W  instructions that passed condition check
//  skip_cnt              out  CNT_W  instructions that failed condition check
// BEHAVIOUR
//  Reset: flags=4'b0000, exec_cnt=0, skip_cnt=0; condition_code_check=0 (state in IDLE).
//  condition_code_check: combinational, 0-cycle latency;
//    = eval(cond_in, flags) when curr_state==LOAD_REG_STATE, else 0.
//  eval table (cond: pass when): 0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N
//    6 VS V | 7 VC !V | 8 HI C&!Z | 9 LS !C|Z | 10 GE N==V | 11 LT N!=V
//    12 GT !Z&(N==V) | 13 LE Z|(N!=V) | 14 AL 1 | 15 NV 0.
//  Flag register (clocked, priority high->low):
//    1. curr_state==ALU_STATE && set_flags : flags <= alu_nzcv
//    2. curr_state==IDLE_STATE && flags_wr  : flags <= flags_wdata
//    3. otherwise hold; flags_wr outside IDLE_STATE is ignored, not queued.
//  New flags are visible from the cycle after ALU_STATE, so the next LOAD_REG_STATE
//  (>=2 cycles later) always sees them.
//  Counters (clocked, per edge where curr_state==LOAD_REG_STATE):
//    check=1 -> exec_cnt+1; check=0 -> skip_cnt+1; each saturates at 2^CNT_W-1.
//    cnt_clr wins over increment in the same cycle (counter -> 0).
//  Counters/flags do not change in FETCH_STATE, or while state is held in IDLE.
//  Async reset mid-instruction: all registers return to reset values immediately;
//  any in-flight flag update is lost.
//  Pure responder: no internal FSM beyond registers; curr_state is the only sequencing
//  input. Illegal/X states impossible (2-bit fully decoded).
// TESTING
//  1 Reset, flags_wr=1 wdata=4'b0100 in IDLE -> flags=4'b0100; LOAD_REG with cond=0(EQ)
//    -> check=1, exec_cnt=1; cond=1(NE) next instr -> check=0, skip_cnt=1.
//  2 Sweep all 16 cond x 16 flag values in LOAD_REG -> check matches eval table; check=0
//    in every other state regardless of cond_in.
//  3 ALU_STATE set_flags=1 alu_nzcv=4'b1001 -> flags=4'b1001 next cycle; with set_flags=0
//    -> flags unchanged; flags_wr=1 during ALU/FETCH -> ignored.
//  4 Preload exec_cnt to 16'hFFFE via 2 cycles short of max, 3 passing instrs -> sticks at
//    16'hFFFF; cnt_clr asserted same edge as a pass -> exec_cnt=0.
//  5 Assert rst_n=0 mid ALU_STATE with set_flags=1 -> flags=0, counters=0, check=0 at once.
//  6 Run with real control FSM: program of 4 instrs (AL, NV, EQ after Z-setting op, NE)
//    -> FSM visits ALU for instrs 1,3 only; exec_cnt=2, skip_cnt=2.

Source files
------------

// File: rtl/cond_code_unit.sv
// Condition-code responder for the fetch/decode/execute control FSM.
// Evaluates the instruction condition field against the NZCV flag register,
// maintains the flags, and keeps saturating executed/skipped counters.
module cond_code_unit #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       curr_state,
   input  logic [3:0]       cond_in,
   input  logic             set_flags,
   input  logic [3:0]       alu_nzcv,
   input  logic             flags_wr,
   input  logic [3:0]       flags_wdata,
   input  logic             cnt_clr,
   output logic             condition_code_check,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   localparam logic [1:0] IDLE_STATE     = 2'd0;
   localparam logic [1:0] FETCH_STATE    = 2'd1;
   localparam logic [1:0] LOAD_REG_STATE = 2'd2;
   localparam logic [1:0] ALU_STATE      = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
   logic             flag_n, flag_z, flag_c, flag_v;
   logic             cond_pass;
   logic             check_c;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Condition field evaluation against the current flags
   always_comb begin
      cond_pass = 1'b0;
      case (cond_in)
         4'd0:  cond_pass = flag_z;
         4'd1:  cond_pass = !flag_z;
         4'd2:  cond_pass = flag_c;
         4'd3:  cond_pass = !flag_c;
         4'd4:  cond_pass = flag_n;
         4'd5:  cond_pass = !flag_n;
         4'd6:  cond_pass = flag_v;
         4'd7:  cond_pass = !flag_v;
         4'd8:  cond_pass = flag_c && !flag_z;
         4'd9:  cond_pass = !flag_c || flag_z;
         4'd10: cond_pass = (flag_n == flag_v);
         4'd11: cond_pass = (flag_n != flag_v);
         4'd12: cond_pass = !flag_z && (flag_n == flag_v);
         4'd13: cond_pass = flag_z || (flag_n != flag_v);
         4'd14: cond_pass = 1'b1;
         4'd15: cond_pass = 1'b0;
      endcase
   end

   // Check is only meaningful while the FSM sits in the register-load state
   assign check_c = (curr_state == LOAD_REG_STATE) && cond_pass;

   // Flag register next state: ALU update beats direct write; direct write only in idle
   always_comb begin
      flags_d = flags_q;
      if ((curr_state == ALU_STATE) && set_flags) begin
         flags_d = alu_nzcv;
      end else if ((curr_state == IDLE_STATE) && flags_wr) begin
         flags_d = flags_wdata;
      end
   end

   // Saturating executed/skipped counters; clear beats increment
   always_comb begin
      exec_cnt_d = exec_cnt_q;
      skip_cnt_d = skip_cnt_q;
      if (cnt_clr) begin
         exec_cnt_d = '0;
         skip_cnt_d = '0;
      end else if (curr_state == LOAD_REG_STATE) begin
         if (check_c) begin
            if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_W'(1);
         end else begin
            if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q    <= 4'b0000;
         exec_cnt_q <= '0;
         skip_cnt_q <= '0;
      end else begin
         flags_q    <= flags_d;
         exec_cnt_q <= exec_cnt_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   assign condition_code_check = check_c;
   assign flags                = flags_q;
   assign exec_cnt             = exec_cnt_q;
   assign skip_cnt             = skip_cnt_q;

   // FETCH_STATE has no dedicated behaviour; keep the encoding referenced
   logic unused_fetch;
   assign unused_fetch = (curr_state == FETCH_STATE);

endmodule

// File: tb/tb_cond_code_unit.sv
// Self-checking bench for cond_code_unit: directed steps, scoreboard of expected
// outputs pushed per driven cycle and popped when the outputs are sampled.
module tb_cond_code_unit;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FET  = 2'd1;
   localparam logic [1:0] ST_LR   = 2'd2;
   localparam logic [1:0] ST_ALU  = 2'd3;

   logic        clk;
   logic        rst_n;
   logic [1:0]  curr_state;
   logic [3:0]  cond_in;
   logic        set_flags;
   logic [3:0]  alu_nzcv;
   logic        flags_wr;
   logic [3:0]  flags_wdata;
   logic        cnt_clr;
   logic        condition_code_check;
   logic [3:0]  flags;
   logic [15:0] exec_cnt;
   logic [15:0] skip_cnt;

   cond_code_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .curr_state(curr_state), .cond_in(cond_in),
      .set_flags(set_flags), .alu_nzcv(alu_nzcv), .flags_wr(flags_wr),
      .flags_wdata(flags_wdata), .cnt_clr(cnt_clr),
      .condition_code_check(condition_code_check), .flags(flags),
      .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        chk;
      logic [3:0]  flg;
      logic [15:0] ex;
      logic [15:0] sk;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   logic [3:0]  m_flags;
   logic [15:0] m_exec;
   logic [15:0] m_skip;
   logic        last_chk;

   // Reference condition evaluation: pairs of opposite conditions share a base term
   function automatic logic ref_eval(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = ~(n ^ v);
         3'd6: base = ~z & ~(n ^ v);
         default: base = 1'b1;
      endcase
      return cond[0] ? ~base : base;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive, push expectation, sample outputs, update model, advance
   task automatic cycle(input string tag, input logic [1:0] st, input logic [3:0] cond,
                        input logic sf, input logic [3:0] alu, input logic fw,
                        input logic [3:0] fwd, input logic clr);
      exp_t e, o;
      curr_state = st; cond_in = cond; set_flags = sf; alu_nzcv = alu;
      flags_wr = fw; flags_wdata = fwd; cnt_clr = clr;
      e.tag = tag;
      e.chk = (st == ST_LR) ? ref_eval(cond, m_flags) : 1'b0;
      e.flg = m_flags;
      e.ex  = m_exec;
      e.sk  = m_skip;
      exp_q.push_back(e);
      #1;
      o = exp_q.pop_front();
      last_chk = condition_code_check;
      cmp({o.tag, ".check"}, 16'(condition_code_check), 16'(o.chk));
      cmp({o.tag, ".flags"}, 16'(flags), 16'(o.flg));
      cmp({o.tag, ".exec"},  exec_cnt, o.ex);
      cmp({o.tag, ".skip"},  skip_cnt, o.sk);
      if (st == ST_ALU && sf)        m_flags = alu;
      else if (st == ST_IDLE && fw)  m_flags = fwd;
      if (clr) begin
         m_exec = 16'h0;
         m_skip = 16'h0;
      end else if (st == ST_LR) begin
         if (o.chk) begin
            if (m_exec != 16'hFFFF) m_exec = m_exec + 16'h1;
         end else begin
            if (m_skip != 16'hFFFF) m_skip = m_skip + 16'h1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] prog_cond [4];
      logic [3:0] visit_mask;
      int         alu_visits;

      rst_n = 1'b0; curr_state = ST_IDLE; cond_in = 4'd0; set_flags = 1'b0;
      alu_nzcv = 4'd0; flags_wr = 1'b0; flags_wdata = 4'd0; cnt_clr = 1'b0;
      m_flags = 4'd0; m_exec = 16'd0; m_skip = 16'd0; last_chk = 1'b0;
      repeat (2) @(negedge clk);
      // Reset state
      cmp("reset.check", 16'(condition_code_check), 16'h0);
      cmp("reset.flags", 16'(flags), 16'h0);
      cmp("reset.exec",  exec_cnt, 16'h0);
      cmp("reset.skip",  skip_cnt, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic: write Z in idle, EQ passes, NE fails
      cycle("t1.wr",  ST_IDLE, 4'd0, 1'b0, 4'd0, 1'b1, 4'b0100, 1'b0);
      cycle("t1.fet", ST_FET,  4'd0, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0);
      cycle("t1.eq",  ST_LR,   4'd0, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0);
      cycle("t1.fet2",ST_FET,  4'd1, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0);
      cycle("t1.ne",  ST_LR,   4'd1, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0);
      cycle("t1.end", ST_IDLE, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0,    1'b0);
      cmp("t1.exec_is_1", exec_cnt, 16'd1);
      cmp("t1.skip_is_1", skip_cnt, 16'd1);

      // Sweep all conditions against all flag values, plus other states
      for (int f = 0; f < 16; f++) begin
         cycle("t2.wr", ST_IDLE, 4'd0, 1'b0, 4'd0, 1'b1, 4'(f), 1'b0);
         for (int c = 0; c < 16; c++) begin
            cycle("t2.lr",   ST_LR,   4'(c), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            cycle("t2.idle", ST_IDLE, 4'(c), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            cycle("t2.fet",  ST_FET,  4'(c), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            cycle("t2.alu",  ST_ALU,  4'(c), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
         end
      end

      // Flag updates from ALU; ignored writes outside idle
      cycle("t3.alu_set",  ST_ALU, 4'd14, 1'b1, 4'b1001, 1'b0, 4'd0,    1'b0);
      cycle("t3.after",    ST_FET, 4'd14, 1'b0, 4'd0,    1'b0, 4'd0,    1'b0);
      cycle("t3.alu_nos",  ST_ALU, 4'd14, 1'b0, 4'b0110, 1'b0, 4'd0,    1'b0);
      cycle("t3.alu_wr",   ST_ALU, 4'd14, 1'b0, 4'b0110, 1'b1, 4'b1111, 1'b0);
      cycle("t3.fet_wr",   ST_FET, 4'd14, 1'b0, 4'd0,    1'b1, 4'b1111, 1'b0);
      cycle("t3.alu_both", ST_ALU, 4'd14, 1'b1, 4'b0010, 1'b1, 4'b1111, 1'b0);
      cycle("t3.hold",     ST_IDLE,4'd14, 1'b0, 4'd0,    1'b0, 4'd0,    1'b0);
      cmp("t3.flags_0010", 16'(flags), 16'h2);

      // Saturation: clear, preload to FFFE, three passes, then clear with a pass
      cycle("t4.clr", ST_LR, 4'd14, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      curr_state = ST_LR; cond_in = 4'd14; cnt_clr = 1'b0;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      @(negedge clk);
      m_exec = 16'hFFFE;
      cycle("t4.p1", ST_LR, 4'd14, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      cycle("t4.p2", ST_LR, 4'd14, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      cycle("t4.p3", ST_LR, 4'd14, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      cmp("t4.sat", exec_cnt, 16'hFFFF);
      cycle("t4.clr_pass", ST_LR,   4'd14, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      cycle("t4.post",     ST_IDLE, 4'd0,  1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

      // Async reset in the middle of an ALU cycle with a pending flag update
      cycle("t5.pre_lr", ST_LR, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      curr_state = ST_ALU; set_flags = 1'b1; alu_nzcv = 4'b1111;
      #2;
      rst_n = 1'b0;
      #1;
      cmp("t5.check", 16'(condition_code_check), 16'h0);
      cmp("t5.flags", 16'(flags), 16'h0);
      cmp("t5.exec",  exec_cnt, 16'h0);
      cmp("t5.skip",  skip_cnt, 16'h0);
      m_flags = 4'd0; m_exec = 16'd0; m_skip = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("t5.after", ST_IDLE, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

      // Program run under a bench-side control FSM: AL(sets Z), NV, EQ, NE
      prog_cond[0] = 4'd14; prog_cond[1] = 4'd15; prog_cond[2] = 4'd0; prog_cond[3] = 4'd1;
      visit_mask = 4'b0000;
      alu_visits = 0;
      for (int k = 0; k < 4; k++) begin
         cycle("t6.fet", ST_FET, prog_cond[k], 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
         cycle("t6.lr",  ST_LR,  prog_cond[k], 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
         if (last_chk) begin
            visit_mask[k] = 1'b1;
            alu_visits++;
            cycle("t6.alu", ST_ALU, prog_cond[k], (k == 0), (k == 0) ? 4'b0100 : 4'b0000,
                  1'b0, 4'd0, 1'b0);
         end
      end
      cycle("t6.idle", ST_IDLE, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      cmp("t6.visits", 16'(visit_mask), 16'h5);
      cmp("t6.alu_count", 16'(alu_visits), 16'd2);
      cmp("t6.exec", exec_cnt, 16'd2);
      cmp("t6.skip", skip_cnt, 16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
